prog_loader: RTL and testbench

//   Writer side of the 1024x16 program memory that the microcontroller fetches from.

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-memory loader: parses a length-prefixed, XOR-checksummed byte stream into
// 16-bit word writes and holds the core in reset until the image verifies.
module prog_loader #(
  parameter int AW        = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wd,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  len_h_q, hi_q, xsum;
  logic [10:0] nwords, wcnt, wcnt_inc, n_in;
  logic        len_bad, last_word;

  // Word count is always 11 bits in the stream, independent of AW.
  assign n_in      = {len_h_q[2:0], in_data};
  assign len_bad   = (len_h_q[7:3] != 5'd0) || (n_in == 11'd0) || (int'(n_in) > MAX_WORDS);
  assign wcnt_inc  = wcnt + 11'd1;
  assign last_word = (wcnt_inc == nwords);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nx = S_LEN_H;
      S_LEN_H: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_LEN_L;
      end
      S_LEN_L: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = len_bad ? S_ERR : S_DATA_H;
      end
      S_DATA_H: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_DATA_L;
      end
      S_DATA_L: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = last_word ? S_CHK : S_DATA_H;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = (in_data == xsum) ? S_DONE : S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_h_q   <= '0;
      hi_q      <= '0;
      xsum      <= '0;
      nwords    <= '0;
      wcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      cpu_reset <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          wcnt      <= '0;
          mem_addr  <= '0;
          xsum      <= '0;
          done      <= 1'b0;
          err       <= 1'b0;
          cpu_reset <= 1'b1;
        end
        S_LEN_H: if (in_valid) begin
          len_h_q <= in_data;
          xsum    <= xsum ^ in_data;
        end
        S_LEN_L: if (in_valid) begin
          nwords <= n_in;
          xsum   <= xsum ^ in_data;
          if (len_bad) err <= 1'b1;
        end
        S_DATA_H: if (in_valid) begin
          hi_q <= in_data;
          xsum <= xsum ^ in_data;
        end
        S_DATA_L: if (in_valid) begin
          mem_we   <= 1'b1;
          mem_addr <= wcnt[AW-1:0];
          mem_wd   <= {hi_q, in_data};
          wcnt     <= wcnt_inc;
          xsum     <= xsum ^ in_data;
        end
        S_CHK: if (in_valid) begin
          if (in_data == xsum) begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            err       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: a stream-level model predicts word writes and
// load outcome; an independent monitor checks every mem_we pulse against the queue.
module tb_prog_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_reset, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wd;

  int n_cmp = 0;
  int n_bad = 0;
  logic [25:0] exp_q[$];
  logic [15:0] wq[$];

  prog_loader #(.AW(AW), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest predicted write.
  logic [25:0] mon_e;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wd);
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_write", {6'd0, mem_addr, mem_wd}, {6'd0, mon_e});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    bit ok = 1'b0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    if (poke) start = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 40; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %0h not accepted, expected accept within 40 cycles", b);
    end
  endtask

  // Issue start with a byte already on the bus; it must not be consumed in IDLE/DONE/ERR.
  task automatic do_start(input logic [7:0] b);
    check("ready_before_start", {31'd0, in_ready}, 32'd0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    start    = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("cpu_reset_loading", {31'd0, cpu_reset}, 32'd1);
  endtask

  // Reference model works on the stream definition: length rules, word list, XOR of bytes.
  task automatic run_load(input logic [7:0] lh, input logic [7:0] ll, input bit corrupt,
                          input int gap_max, input bit poke);
    int         n;
    bit         len_ok, exp_done;
    logic [7:0] bytes[$];
    logic [7:0] x;
    n      = int'({lh[2:0], ll});
    len_ok = (lh[7:3] == 5'd0) && (n >= 1) && (n <= 1024);
    bytes  = {lh, ll};
    if (len_ok) begin
      for (int i = 0; i < n; i++) begin
        bytes.push_back(wq[i][15:8]);
        bytes.push_back(wq[i][7:0]);
        exp_q.push_back({i[9:0], wq[i]});
      end
      x = 8'd0;
      foreach (bytes[i]) x = x ^ bytes[i];
      bytes.push_back(corrupt ? (x ^ 8'h01) : x);
    end
    exp_done = len_ok && !corrupt;
    do_start(lh);
    foreach (bytes[i]) send_byte(bytes[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0, poke);
    in_valid = 1'b0;
    check("done", {31'd0, done}, {31'd0, exp_done});
    check("err", {31'd0, err}, {31'd0, !exp_done});
    check("cpu_reset_end", {31'd0, cpu_reset}, {31'd0, !exp_done});
    check("busy_end", {31'd0, busy}, 32'd0);
    check("ready_end", {31'd0, in_ready}, 32'd0);
    check("writes_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wd"}, {16'd0, mem_wd}, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic image, good and bad checksum.
    wq = {16'h1234, 16'hABCD};
    run_load(8'h00, 8'h02, 1'b0, 0, 1'b0);
    run_load(8'h00, 8'h02, 1'b1, 0, 1'b0);

    // Length rejects and the largest legal length header boundary.
    run_load(8'h04, 8'h01, 1'b0, 0, 1'b0);
    run_load(8'h00, 8'h00, 1'b0, 0, 1'b0);
    run_load(8'h08, 8'h01, 1'b0, 0, 1'b0);

    // Gappy valid with start pokes during the load.
    wq = {16'h1234, 16'hABCD};
    run_load(8'h00, 8'h02, 1'b0, 3, 1'b1);

    // Full-size ramp image.
    wq.delete();
    for (int i = 0; i < 1024; i++) wq.push_back(16'(i));
    run_load(8'h04, 8'h00, 1'b0, 0, 1'b0);

    // Randomized short images.
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 16);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      run_load(8'h00, 8'(n), ($urandom_range(0, 2) == 0), 3, ($urandom_range(0, 1) == 1));
    end

    // Asynchronous reset mid-load, then a clean reload.
    wq = {16'h1234, 16'hABCD};
    exp_q.push_back({10'd0, 16'h1234});
    do_start(8'h00);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    check("midreset_writes", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_load(8'h00, 8'h02, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
